cam_capture_ctrl: RTL

Frame-capture sequencer between the camera pixel decoder and the dual-port frame buffer's write port. It converts the camera pixel stream into a windowed WIN_W×WIN_H write sequence. Live/freeze and single-shot snapshot requests take effect only on frame boundaries, so a stored frame is never torn. A 2-entry write FIFO absorbs buffer back-pressure.

---
 rtl/cam_capture_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer: windows the camera pixel stream into frame-buffer writes,
// switching live/freeze/snapshot only on frame boundaries. Optional CAP_STATS_EN adds drop/short-frame stats.
module cam_capture_ctrl #(
  parameter int SRC_W = 640,
  parameter int SRC_H = 480,
  parameter int WIN_W = 256,
  parameter int WIN_H = 256,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode_live,
  input  logic          snap_req,
  input  logic          pix_valid,
  input  logic [15:0]   pix_data,
  input  logic          frame_done,
  input  logic          buf_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic [1:0]    state,
  output logic [7:0]    frame_cnt,
  output logic          capture_done,
  output logic          overflow
`ifdef CAP_STATS_EN
  ,
  output logic [15:0]   drop_cnt,
  output logic          short_frame
`endif
);
  localparam int HB = $clog2(WIN_W);
  localparam int VB = $clog2(WIN_H);
  localparam int HW = $clog2(SRC_W);
  localparam int VW = $clog2(SRC_H + 1);

  typedef enum logic [1:0] {IDLE = 2'b00, ARM = 2'b01, CAPTURE = 2'b10, HOLD = 2'b11} state_t;

  state_t          cur, nxt;
  logic [HW-1:0]   h;
  logic [VW-1:0]   v;
  logic            snap_pend, live_q;
  logic            in_cap, arm_start, frame_end;
  logic            win_hit, push, pop, drop;
  logic [1:0]      cnt;
  logic [AW+15:0]  e0, e1, entry;

  always_ff @(posedge clk or posedge rst)
    if (rst) cur <= IDLE;
    else     cur <= nxt;

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (mode_live || snap_req) nxt = ARM;
      ARM:     if (frame_done) nxt = CAPTURE;
      CAPTURE: if (frame_done) nxt = (mode_live && !snap_pend) ? CAPTURE : HOLD;
      HOLD:    if ((mode_live && !live_q) || snap_req) nxt = ARM;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    state     = cur;
    in_cap    = (cur == CAPTURE);
    arm_start = (cur == ARM) && frame_done;
    frame_end = in_cap && frame_done;
  end

  // A pixel coincident with frame_done still belongs to the ending frame.
  assign win_hit = (32'(h) < WIN_W) && (32'(v) < WIN_H);
  assign push    = in_cap && pix_valid && win_hit;
  assign entry   = {v[VB-1:0], h[HB-1:0], pix_data};

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (arm_start || frame_end) begin
      h <= '0;
      v <= '0;
    end else if (in_cap && pix_valid) begin
      if (32'(h) == SRC_W - 1) begin
        h <= '0;
        if (32'(v) != SRC_H) v <= v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      snap_pend    <= 1'b0;
      live_q       <= 1'b0;
      frame_cnt    <= '0;
      capture_done <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      live_q       <= mode_live;
      capture_done <= frame_end;
      if (frame_end)     snap_pend <= 1'b0;
      else if (snap_req) snap_pend <= 1'b1;
      if (frame_end) frame_cnt <= frame_cnt + 8'd1;
      if (drop)      overflow  <= 1'b1;
    end

  // Two-entry FIFO; head lives in e0 and drives the write port directly.
  assign pop  = (cnt != 2'd0) && buf_ready;
  assign drop = push && (cnt == 2'd2) && !pop;
  assign wr_en = pop;
  assign {wr_addr, wr_data} = e0;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      case (cnt)
        2'd0: if (push) begin
          e0  <= entry;
          cnt <= 2'd1;
        end
        2'd1: begin
          if (push && pop) e0 <= entry;
          else if (push) begin
            e1  <= entry;
            cnt <= 2'd2;
          end else if (pop) cnt <= 2'd0;
        end
        2'd2: if (pop) begin
          e0 <= e1;
          if (push) e1 <= entry;
          else      cnt <= 2'd1;
        end
        default: cnt <= 2'd0;
      endcase
    end

`ifdef CAP_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      drop_cnt    <= '0;
      short_frame <= 1'b0;
    end else begin
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (frame_end && 32'(v) < WIN_H)  short_frame <= 1'b1;
    end
`endif

endmodule
